pc_branch_unit: RTL
===================

Name: pc_branch_unit

Overview:
- Writer side of the program counter's load interface; sole driver of the PC's `wr_en` and `counteradress`.
- Converts decoder requests into single-cycle PC loads: JMP (absolute), CALL (push return address, jump) and RET (pop, jump).
- Holds a LIFO return-address stack; sits between the instruction decoder and the PC.

Parameters:
- PC_WIDTH, 8, width of PC, targets and stack entries.
- STACK_DEPTH, 4, number of return-address entries (power of two, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- res_n  input  1  asynchronous active-low reset.
- pc  input  PC_WIDTH  current PC value from the program counter.
- jmp  input  1  jump request, target from `target`.
- call  input  1  call request, target from `target`.
- ret  input  1  return request, target from stack top.
- target  input  PC_WIDTH  jump/call destination.
- clr_err  input  1  clears sticky error flags.
- wr_en  output  1  PC load enable (to PC `wr_en`).
- counteradress  output  PC_WIDTH  PC load value (to PC `counteradress`).
- depth  output  $clog2(STACK_DEPTH)+1  current stack occupancy.
- stack_ovf  output  1  sticky: CALL attempted while full.
- stack_unf  output  1  sticky: RET attempted while empty.
- cmd_err  output  1  sticky: more than one of jmp/call/ret asserted in a cycle.

Behaviour:
- Reset (res_n=0, async): depth=0, all stack entries 0, stack_ovf=stack_unf=cmd_err=0. wr_en=0 and counteradress=0 while in reset, regardless of requests.
- wr_en and counteradress are combinational from requests and stack top, so the PC loads on the same rising edge the request is sampled. Zero-cycle latency request->PC load; PC shows the new value after that edge.
- Stack and flags update on the rising edge.
- Legal cycle: at most one of jmp/call/ret high.
  - JMP: wr_en=1, counteradress=target; stack unchanged.
  - CALL, depth<STACK_DEPTH: wr_en=1, counteradress=target. At the edge, push (pc+1) mod 2^PC_WIDTH and increment depth. pc=255 pushes 0 (PC_WIDTH=8).
  - CALL, depth==STACK_DEPTH: wr_en=0, no push, stack_ovf<=1; PC continues incrementing.
  - RET, depth>0: wr_en=1, counteradress=top entry; pop at the edge.
  - RET, depth==0: wr_en=0, stack_unf<=1, counteradress=0.
- Idle (no request): wr_en=0, counteradress=0.
- Multiple requests high: wr_en=0, no stack change, cmd_err<=1.
- Sticky flags hold until clr_err=1 at an edge, or until reset. If clr_err and a new error occur in the same cycle, the new error wins (flag stays 1).
- Reset mid-operation: stack discarded immediately, wr_en drops asynchronously.
- Stack storage: array indexed by depth-1; no wrap or overwrite.

Optional Feature:
- Macro: PC_BRANCH_COND_EN.
- Defined: adds inputs `jz` (1 bit) and `zero_flag` (1 bit).
  - jz counts as a request in the one-hot check.
  - jz with zero_flag=1 behaves as JMP.
  - jz with zero_flag=0: wr_en=0, no error.
- Undefined: ports absent; behaviour as above.

Decomposition:
- Shared package jac_pkg: PC_WIDTH, STACK_DEPTH defaults, request-type enum (REQ_NONE, REQ_JMP, REQ_CALL, REQ_RET, REQ_JZ), return-address increment constant.
- One natural sub-module `ret_addr_lifo`: push/pop/top/depth/full/empty, parameterised by width and depth.
- pc_branch_unit keeps request decode, PC-load muxing and sticky flags.

Test Plan:
- Reset then idle 3 cycles with PC counting 0,1,2 -> wr_en=0 throughout, depth=0, all flags 0.
- jmp=1, target=32 for one cycle at pc=2 -> wr_en=1, counteradress=32 that cycle; PC reads 32 then 33.
- call target=64 at pc=10; later ret at pc=70 -> call cycle: counteradress=64, depth 0->1. Ret cycle: counteradress=11, depth 1->0; PC resumes 11, 12.
- Five nested calls with STACK_DEPTH=4 -> first four load and push; fifth gives wr_en=0, stack_ovf=1, depth=4. Four rets return addresses in reverse order. A fifth ret sets stack_unf=1. clr_err clears both flags.
- call at pc=255, target=5 -> pushed value 0; later ret loads 0.
- call and ret both high -> wr_en=0, depth unchanged, cmd_err=1; assert res_n=0 mid-stack (depth=2) -> depth=0 and wr_en=0 immediately.

Source files
------------

// File: rtl/jac_pkg.sv
// Shared definitions for the PC branch unit: size defaults, request encoding
// and the return-address increment.
package jac_pkg;

   localparam int DEF_PC_WIDTH    = 8;
   localparam int DEF_STACK_DEPTH = 4;
   localparam int RET_INC         = 1;

   typedef enum logic [2:0] {
      REQ_NONE,
      REQ_JMP,
      REQ_CALL,
      REQ_RET,
      REQ_JZ
   } req_e;

endpackage

// File: rtl/pc_branch_unit_lifo.sv
// Return-address LIFO: storage indexed by depth-1, no wrap and no overwrite.
// Pushing while full or popping while empty is ignored.
module ret_addr_lifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int DW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic [DW-1:0]    depth,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    wr_idx;

   assign full    = (depth == DW'(DEPTH));
   assign empty   = (depth == '0);
   assign top_idx = AW'(depth - 1'b1);
   assign wr_idx  = depth[AW-1:0];
   assign top     = empty ? '0 : mem[top_idx];

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         depth <= '0;
         // NOTE: the entries are reset too, so a discarded stack never leaks old return addresses.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !full) begin
         mem[wr_idx] <= din;
         depth       <= depth + 1'b1;
      end else if (pop && !empty) begin
         depth <= depth - 1'b1;
      end
   end

endmodule

// File: rtl/pc_branch_unit.sv
// Drives the PC load interface for JMP/CALL/RET with a return-address stack.
// Define PC_BRANCH_COND_EN to add the conditional jump (jz, zero_flag).
module pc_branch_unit
   import jac_pkg::*;
#(
   parameter int PC_WIDTH    = DEF_PC_WIDTH,
   parameter int STACK_DEPTH = DEF_STACK_DEPTH,
   localparam int DW         = $clog2(STACK_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                res_n,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                jmp,
   input  logic                call,
   input  logic                ret,
`ifdef PC_BRANCH_COND_EN
   input  logic                jz,
   input  logic                zero_flag,
`endif
   input  logic [PC_WIDTH-1:0] target,
   input  logic                clr_err,
   output logic                wr_en,
   output logic [PC_WIDTH-1:0] counteradress,
   output logic [DW-1:0]       depth,
   output logic                stack_ovf,
   output logic                stack_unf,
   output logic                cmd_err
);

   logic                jz_req;
   logic                jz_taken;
   logic [2:0]          n_req;
   req_e                req;
   logic                push;
   logic                pop;
   logic                full;
   logic                empty;
   logic [PC_WIDTH-1:0] top;
   logic                ovf_evt;
   logic                unf_evt;
   logic                cmd_evt;

`ifdef PC_BRANCH_COND_EN
   assign jz_req   = jz;
   assign jz_taken = zero_flag;
`else
   assign jz_req   = 1'b0;
   assign jz_taken = 1'b0;
`endif

   assign n_req = {2'b0, jmp} + {2'b0, call} + {2'b0, ret} + {2'b0, jz_req};

   always_comb begin
      req = REQ_NONE;
      if (jmp)         req = REQ_JMP;
      else if (call)   req = REQ_CALL;
      else if (ret)    req = REQ_RET;
      else if (jz_req) req = REQ_JZ;
   end

   // Load path is combinational so the PC takes the new value on the same edge
   // that samples the request; reset forces it idle asynchronously.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      wr_en         = 1'b0;
      counteradress = '0;
      push          = 1'b0;
      pop           = 1'b0;
      ovf_evt       = 1'b0;
      unf_evt       = 1'b0;
      cmd_evt       = 1'b0;
      if (n_req > 3'd1) begin
         cmd_evt = 1'b1;
      end else begin
         case (req)
            REQ_JMP: begin
               wr_en         = 1'b1;
               counteradress = target;
            end
            REQ_CALL: begin
               if (!full) begin
                  wr_en         = 1'b1;
                  counteradress = target;
                  push          = 1'b1;
               end else begin
                  ovf_evt = 1'b1;
               end
            end
            REQ_RET: begin
               if (!empty) begin
                  wr_en         = 1'b1;
                  counteradress = top;
                  pop           = 1'b1;
               end else begin
                  unf_evt = 1'b1;
               end
            end
            REQ_JZ: begin
               if (jz_taken) begin
                  wr_en         = 1'b1;
                  counteradress = target;
               end
            end
            default: ;
         endcase
      end
      if (!res_n) begin
         wr_en         = 1'b0;
         counteradress = '0;
      end
   end

   ret_addr_lifo #(
      .WIDTH (PC_WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_lifo (
      .clk   (clk),
      .res_n (res_n),
      .push  (push),
      .pop   (pop),
      .din   (pc + PC_WIDTH'(RET_INC)),
      .top   (top),
      .depth (depth),
      .full  (full),
      .empty (empty)
   );

   // A new error in the clearing cycle wins over clr_err.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         stack_ovf <= 1'b0;
         stack_unf <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         stack_ovf <= (stack_ovf & ~clr_err) | ovf_evt;
         stack_unf <= (stack_unf & ~clr_err) | unf_evt;
         cmd_err   <= (cmd_err & ~clr_err) | cmd_evt;
      end
   end

endmodule
